// File: rtl/uart_fifo_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_tx_pkg;

    // Frame sequencer states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Default build: 100 MHz core clock, 115200 baud, 8-bit words.
    localparam int DEF_CLKS_PER_BIT = 868;
    localparam int DEF_DATA_WIDTH   = 8;

    // Counter widths for the default build.
    localparam int BAUD_CNT_W = $clog2(DEF_CLKS_PER_BIT);
    localparam int BIT_CNT_W  = $clog2(DEF_DATA_WIDTH);

    // Line levels.
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_fifo_tx_if.sv
// Read port of the TX FIFO as seen by the UART transmitter.
// Latency: read data is valid the cycle after the read strobe.
// Backpressure: the consumer only pops while the empty flag is low.
interface uart_fifo_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  fifo_empty;
    logic                  fifo_read;

    // The transmitter drives the pop strobe and consumes data/empty.
    modport master (
        input  fifo_data_out,
        input  fifo_empty,
        output fifo_read
    );

    // The FIFO side supplies data/empty and receives the pop strobe.
    modport slave (
        output fifo_data_out,
        output fifo_empty,
        input  fifo_read
    );
endinterface

// File: rtl/uart_fifo_tx_baud_tick.sv
// Bit-period timer: pulses tick in the last clock of every CLKS_PER_BIT window.
// Latency: first tick arrives CLKS_PER_BIT cycles after clear drops.
// Backpressure: none; clear holds the count at zero.
module uart_baud_tick
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int             W    = cnt_width(CLKS_PER_BIT);
    localparam logic [W-1:0]   LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: held at zero while cleared, wraps to zero at each bit boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_fifo_tx.sv
// Pops bytes from the TX FIFO and serialises them as UART frames (start, data LSB first, parity, stop).
// Latency: FIFO pop 1 cycle after non-empty is sampled in idle, start bit 3 cycles after.
// Backpressure: never pops an empty FIFO; enable low stops new frames but finishes the current one.
module uart_fifo_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic           clock,
    input  logic           rst_n,
    input  logic           enable,
    uart_fifo_tx_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic           tx_done
);
    localparam int              BW       = cnt_width(DATA_WIDTH);
    localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic            LAST_STP = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_fifo_tx: CLKS_PER_BIT must be at least 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $error("uart_fifo_tx: STOP_BITS must be 1 or 2");
    end

    tx_state_e             state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  rd_q, rd_d;
    logic                  baud_clr;
    logic                  baud_tick;
    logic                  last_stop;
    logic                  can_fetch;

    // The bit timer only runs in bit-timed states, so it always starts a bit at zero.
    assign baud_clr  = (state_q == ST_IDLE) || (state_q == ST_FETCH) || (state_q == ST_LOAD);
    assign last_stop = (stop_cnt_q == LAST_STP);
    assign can_fetch = enable && !fifo.fifo_empty;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clock (clock),
        .rst_n (rst_n),
        .clear (baud_clr),
        .tick  (baud_tick)
    );

    // Frame sequencer next state; line level and pop strobe are derived from the next state
    // so they can be registered without adding a cycle of latency.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tx_d       = IDLE_LEVEL;
        rd_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (can_fetch) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d    = fifo.fifo_data_out;
                parity_d   = (^fifo.fifo_data_out) ^ (PARITY_ODD != 0);
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
                state_d    = ST_START;
            end
            ST_START: begin
                if (baud_tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (last_stop) begin
                        state_d = can_fetch ? ST_FETCH : ST_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_START:  tx_d = START_LEVEL;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   tx_d = IDLE_LEVEL;
        endcase
        rd_d = (state_d == ST_FETCH);
    end

    // State, datapath and registered outputs; reset drops any frame in flight and idles the line.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= IDLE_LEVEL;
            rd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            rd_q       <= rd_d;
        end
    end

    assign tx             = tx_q;
    assign fifo.fifo_read = rd_q;
    assign busy           = (state_q != ST_IDLE);
    assign tx_done        = (state_q == ST_STOP) && baud_tick && last_stop;

endmodule
